// File: rtl/uart_tx_param.sv
// Single-clock UART transmitter: LSB-first framing with configurable width, parity and stop bits.
// Optional break generator compiled in with `define UART_TX_BREAK_EN (adds input break_i).
module uart_tx_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BAUD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic [BAUD_W-1:0] baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic [DATA_W-1:0] data_i,
    input  logic              empty_i,
`ifdef UART_TX_BREAK_EN
    input  logic              break_i,
`endif
    output logic              re_o,
    output logic              tx,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned BC_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   cnt_q, cnt_d;
    logic [BAUD_W-1:0]   div_q, div_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                stop2_q, stop2_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                brk_active;
    logic                bit_tick;
    logic                last_stop;

`ifdef UART_TX_BREAK_EN
    assign brk_active = break_i;
`else
    assign brk_active = 1'b0;
`endif

    assign bit_tick  = (cnt_q == div_q - BAUD_W'(1));
    assign last_stop = !stop2_q || stop_cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        re_o       = 1'b0;

        if (state_q inside {START, DATA, PARITY, STOP})
            cnt_d = bit_tick ? '0 : cnt_q + BAUD_W'(1);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (brk_active) begin
                    tx_d = 1'b0;
                end else if (tx_en && !empty_i) begin
                    re_o    = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d    = data_i;
                div_d      = (baud_div < BAUD_W'(2)) ? BAUD_W'(2) : baud_div;
                par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_bit_d  = (^data_i) ^ (parity_mode == 2'b01);
                stop2_d    = stop2;
                cnt_d      = '0;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                tx_d       = 1'b0;
                state_d    = START;
            end
            START: begin
                if (bit_tick) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            tx_d    = par_bit_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        tx_d      = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                // done is registered, so raise it one cycle ahead of the final tick
                if (last_stop && (cnt_q == div_q - BAUD_W'(2)))
                    done_d = 1'b1;
                if (bit_tick) begin
                    if (last_stop) begin
                        stop_cnt_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= BAUD_W'(2);
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign tx     = tx_q;
    assign done_o = done_q;
    assign busy_o = (state_q != IDLE) || brk_active;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: table of hand-computed frames plus corner-case sequences.
// Break-generator checks run when built with `define UART_TX_BREAK_EN.
module tb_uart_tx_param;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BAUD_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tx_en = 1'b0;
    logic [BAUD_W-1:0] baud_div = 16'd4;
    logic [1:0]        parity_mode = 2'b00;
    logic              stop2 = 1'b0;
    logic [DATA_W-1:0] data_i;
    logic              empty_i;
    logic              re_o, tx, busy_o, done_o;
`ifdef UART_TX_BREAK_EN
    logic              break_i = 1'b0;
`endif

    logic [7:0]  fifo_mem [0:15];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    int unsigned re_cnt = 0;
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    uart_tx_param #(.DATA_W(DATA_W), .BAUD_W(BAUD_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_en       (tx_en),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .data_i      (data_i),
        .empty_i     (empty_i),
`ifdef UART_TX_BREAK_EN
        .break_i     (break_i),
`endif
        .re_o        (re_o),
        .tx          (tx),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    // FIFO model: read data appears one clk after the strobe
    assign empty_i = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (re_o) begin
            re_cnt <= re_cnt + 1;
            if (!empty_i) begin
                data_i <= fifo_mem[rd_ptr % 16];
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    typedef struct {
        logic [15:0] div;
        logic [1:0]  pm;
        logic        s2;
        logic [7:0]  data;
        logic [11:0] bits;     // expected line levels, bit 0 = start bit
        int unsigned nbits;
        int unsigned bit_len;  // effective clk per bit
        int unsigned len;      // clk from re_o to last stop cycle inclusive
        bit          mut;
    } vec_t;

    vec_t tv [8];
    vec_t bv [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr % 16] = b;
        wr_ptr++;
    endtask

    // action: 0 none, 1 change config mid-frame, 2 drop tx_en mid-frame
    task automatic check_frame(input string tag, input vec_t v, input bit expect_next,
                               input int unsigned action);
        int unsigned t;
        t = 0;
        while (!re_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!re_o) begin
            chk({tag, " re_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, " idle_tx"}, tx, 1);
        chk({tag, " idle_busy"}, busy_o, 0);
        for (int unsigned c = 1; c <= v.len; c++) begin
            @(negedge clk);
            if (c == 5 && action == 1) begin
                baud_div    = 16'd8;
                parity_mode = 2'b10;
            end
            if (c == 5 && action == 2) tx_en = 1'b0;
            if (c < v.len) begin
                chk({tag, " busy"}, busy_o, 1);
                chk({tag, " no_re"}, re_o, 0);
                if (c == 1) chk({tag, " load_tx"}, tx, 1);
                else        chk({tag, " tx_bit"}, tx, v.bits[(c - 2) / v.bit_len]);
                chk({tag, " done"}, done_o, (c == v.len - 1) ? 1 : 0);
            end else begin
                chk({tag, " end_busy"}, busy_o, 0);
                chk({tag, " end_tx"}, tx, 1);
                chk({tag, " end_done"}, done_o, 0);
                chk({tag, " end_re"}, re_o, expect_next ? 1 : 0);
            end
        end
    endtask

    initial begin
        int unsigned re_before;

        tv[0] = '{16'd4, 2'b00, 1'b0, 8'hA5, 12'b001101001010, 10, 4, 42, 1'b0};
        tv[1] = '{16'd2, 2'b10, 1'b0, 8'h07, 12'b011000001110, 11, 2, 24, 1'b0};
        tv[2] = '{16'd2, 2'b01, 1'b0, 8'h07, 12'b010000001110, 11, 2, 24, 1'b0};
        tv[3] = '{16'd2, 2'b00, 1'b1, 8'h3C, 12'b011001111000, 11, 2, 24, 1'b0};
        tv[4] = '{16'd0, 2'b11, 1'b0, 8'h81, 12'b001100000010, 10, 2, 22, 1'b0};
        tv[5] = '{16'd3, 2'b10, 1'b1, 8'h00, 12'b110000000000, 12, 3, 38, 1'b0};
        tv[6] = '{16'd4, 2'b00, 1'b0, 8'h5A, 12'b001010110100, 10, 4, 42, 1'b1};
        tv[7] = '{16'd8, 2'b10, 1'b0, 8'h01, 12'b011000000010, 11, 8, 90, 1'b0};
        bv[0] = '{16'd2, 2'b00, 1'b0, 8'h55, 12'b001010101010, 10, 2, 22, 1'b0};
        bv[1] = '{16'd2, 2'b00, 1'b0, 8'h0F, 12'b001000011110, 10, 2, 22, 1'b0};
        bv[2] = '{16'd2, 2'b00, 1'b0, 8'hF0, 12'b001111100000, 10, 2, 22, 1'b0};

        #12;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_re", re_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        tx_en = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("empty_no_re", re_o, 0);
        end
        tx_en = 1'b0;
        push(tv[0].data);
        repeat (5) begin
            @(negedge clk);
            chk("disabled_no_re", re_o, 0);
        end

        for (int unsigned i = 0; i < 8; i++) begin
            baud_div    = tv[i].div;
            parity_mode = tv[i].pm;
            stop2       = tv[i].s2;
            tx_en       = 1'b1;
            if (i != 0) push(tv[i].data);
            #1;
            check_frame($sformatf("vec%0d", i), tv[i], 1'b0, tv[i].mut ? 1 : 0);
        end

        baud_div = 16'd2; parity_mode = 2'b00; stop2 = 1'b0;
        re_before = re_cnt;
        push(bv[0].data); push(bv[1].data); push(bv[2].data);
        #1;
        check_frame("burst0", bv[0], 1'b1, 0);
        check_frame("burst1", bv[1], 1'b1, 0);
        check_frame("burst2", bv[2], 1'b0, 0);
        chk("burst_re_count", re_cnt - re_before, 3);

        baud_div = tv[0].div; parity_mode = tv[0].pm; stop2 = tv[0].s2;
        re_before = re_cnt;
        push(8'hA5); push(8'hA5);
        #1;
        check_frame("en_drop", tv[0], 1'b0, 2);
        repeat (10) @(negedge clk);
        chk("en_drop_re_count", re_cnt - re_before, 1);
        chk("en_drop_idle", busy_o, 0);
        tx_en = 1'b1;
        #1;
        check_frame("en_resume", tv[0], 1'b0, 0);

        push(8'hA5);
        #1;
        chk("rst_mid_re", re_o, 1);
        repeat (19) @(negedge clk);
        chk("rst_mid_busy_before", busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_done", done_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        baud_div = tv[4].div; parity_mode = tv[4].pm; stop2 = tv[4].s2;
        push(tv[4].data);
        #1;
        check_frame("after_rst", tv[4], 1'b0, 0);

`ifdef UART_TX_BREAK_EN
        re_before = re_cnt;
        break_i = 1'b1;
        push(tv[0].data);
        baud_div = tv[0].div; parity_mode = tv[0].pm; stop2 = tv[0].s2;
        #1;
        chk("brk_no_re0", re_o, 0);
        chk("brk_busy0", busy_o, 1);
        repeat (20) begin
            @(negedge clk);
            chk("brk_tx", tx, 0);
            chk("brk_no_re", re_o, 0);
            chk("brk_busy", busy_o, 1);
        end
        tx_en = 1'b0;
        break_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("brk_release_tx", tx, 1);
        chk("brk_release_busy", busy_o, 0);
        chk("brk_re_count", re_cnt - re_before, 0);
        tx_en = 1'b1;
        #1;
        check_frame("after_brk", tv[0], 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter for the AHB UART peripheral. It replaces the divided-clock transmitter with a single-clock design driven by a per-bit clock-enable. It pops bytes from the TX FIFO and serialises them LSB-first, with a configurable data width, parity mode and stop-bit count. An optional break generator can be compiled in.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9.
- BAUD_W, 16, width of the baud divisor.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- tx_en  input  1  transmitter enable; gates new FIFO reads only.
- baud_div  input  BAUD_W  clk cycles per bit; values 0 and 1 are treated as 2.
- parity_mode  input  2  00 = none, 01 = odd, 10 = even, 11 = none.
- stop2  input  1  0 = one stop bit, 1 = two stop bits.
- data_i  input  DATA_W  FIFO read data, valid one clk after re_o.
- empty_i  input  1  FIFO empty flag.
- re_o  output  1  FIFO read strobe, one clk wide.
- tx  output  1  serial line; idles high.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-clk pulse in the last cycle of the final stop bit.

## Operation
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx = 1. If tx_en && !empty_i, assert re_o (combinational, same cycle) and go to LOAD.
- LOAD (1 clk): latch data_i into the shift register. Also latch baud_div (clamped to a minimum of 2), parity_mode and stop2. Go to START. All four values stay fixed for the rest of the frame; input changes mid-frame are ignored.
- Baud counter: cleared in LOAD. It counts 0..div-1 while in START/DATA/PARITY/STOP. bit_tick = (cnt == div-1); the counter wraps to 0 on bit_tick.
- START: tx = 0 for one bit time, then go to DATA.
- DATA: tx = shift[0]. On each bit_tick, shift right and increment bit_cnt. After DATA_W bits, go to PARITY if parity is enabled, else go to STOP.
- PARITY: tx = ^data for even parity, ~^data for odd parity. Parity is computed over the latched data at LOAD, not accumulated bit by bit.
- STOP: tx = 1 for one bit time, or two if stop2 was latched. Then go to IDLE and pulse done_o.
- tx_en falling mid-frame: the current frame completes; no new read is issued.
- empty_i is only sampled in IDLE. re_o is never asserted when empty_i = 1.
- Reset, asynchronous at any point: state = IDLE, tx = 1, re_o = 0, busy_o = 0, done_o = 0, counters = 0. A frame in progress is abandoned.

## Timing
- Read latency: re_o in cycle N, data latched in N+1 (LOAD), tx falls in N+2.
- Each bit is exactly div clk cycles long.
- Frame length in clk: div × (1 + DATA_W + P + S) + 2 overhead cycles (IDLE, LOAD). P is 0 or 1; S is 1 or 2.
- Back-to-back frames: after the final stop bit, tx stays high for exactly 2 extra clk (one IDLE, one LOAD) before the next start bit.
- done_o and the STOP→IDLE transition coincide with the final bit_tick.
- tx is a registered output; it has no glitches.

## Configuration
- UART_TX_BREAK_EN defined: adds a 1-bit input port break_i.
  - While in IDLE with break_i = 1: tx = 0, no FIFO reads, busy_o = 1.
  - When break_i falls: return to normal IDLE behaviour on the next clk.
  - break_i asserted mid-frame takes effect only after that frame's STOP completes.
- UART_TX_BREAK_EN undefined: break_i port is absent and tx is never driven low outside START/DATA/PARITY.

## Test plan
- DATA_W=8, div=4, parity none, stop2=0, FIFO holds 0xA5 -> re_o one pulse; tx = 0,1,0,1,0,0,1,0,1,1, each held 4 clk; done_o pulses once; total 42 clk from re_o.
- div=2, even parity, data 0x07 -> parity bit = 1; odd parity, same data -> parity bit = 0; stop2=1 -> stop high for 4 clk.
- FIFO holds 3 bytes, tx_en=1 -> three contiguous frames, 2-clk high gap between each; re_o pulses exactly 3 times; no read while empty_i=1.
- baud_div changed from 4 to 8 and parity_mode changed mid-frame -> current frame unchanged; next frame uses div=8.
- rst_n pulsed low during DATA bit 3 -> tx = 1, busy_o = 0 immediately; after release, a clean new frame starts from IDLE.
- With UART_TX_BREAK_EN, break_i=1 for 20 clk in IDLE with a non-empty FIFO -> tx low for 20 clk, no re_o; normal frame follows.
